// File: rtl/pool2x2_pkg.sv
// Shared geometry defaults, FSM encoding and pooled-plane sizing for the 2x2 max-pool writer.
package pool2x2_pkg;

    localparam int DEF_COLS   = 28;
    localparam int DEF_ROWS   = 28;
    localparam int DEF_PLANES = 6;
    localparam int DEF_DW     = 16;
    localparam int DEF_AW     = 16;

    localparam int POOLED_PLANE_SIZE = (DEF_ROWS / 2) * (DEF_COLS / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int pooled_size(input int rows, input int cols);
        return (rows / 2) * (cols / 2);
    endfunction

endpackage

// File: rtl/pool2x2_writer_linebuf.sv
// Half-width line buffer holding the top-row pair maxima until the matching bottom row arrives.
module pool_linebuf #(
    parameter int DEPTH = 14,
    parameter int DW    = 16,
    parameter int LAW   = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LAW-1:0]       waddr,
    input  logic signed [DW-1:0] wdata,
    input  logic [LAW-1:0]       raddr,
    output logic signed [DW-1:0] rdata
);

    logic signed [DW-1:0] mem [DEPTH];

    // NOTE: no reset on the array; every entry is written on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pool2x2_writer.sv
// Streams a conv output plane in raster order and writes the 2x2 signed max of each window.
module pool2x2_writer
    import pool2x2_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int PLANES = DEF_PLANES,
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic signed [DW-1:0] wr_data,
    output logic                 plane_done,
    output logic                 busy,
    output logic                 done
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int PW  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int LAW = $clog2(COLS / 2);
    localparam int PSZ = pooled_size(ROWS, COLS);

    state_t state, state_next;

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [PW-1:0]        plane;
    logic signed [DW-1:0] pair;
    logic signed [DW-1:0] lb_rdata;
    logic signed [DW-1:0] top_max;
    logic signed [DW-1:0] win_max;
    logic                 accept;
    logic                 entering;
    logic                 last_col, last_row, last_plane;
    logic                 final_write;
    logic                 lb_we;
    logic [31:0]          addr_full;

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign accept     = in_valid && (state == ST_RUN);
    assign entering   = start && (state != ST_RUN);
    assign last_col   = (col == CW'(COLS - 1));
    assign last_row   = (row == RW'(ROWS - 1));
    assign last_plane = (plane == PW'(PLANES - 1));

    assign top_max   = smax(pair, in_data);
    assign win_max   = smax(top_max, lb_rdata);
    assign addr_full = 32'(plane) * 32'(PSZ) + 32'(row >> 1) * 32'(COLS / 2) + 32'(col >> 1);
    assign lb_we     = accept && !row[0] && col[0];

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    pool_linebuf #(
        .DEPTH(COLS / 2),
        .DW   (DW),
        .LAW  (LAW)
    ) u_linebuf (
        .clk  (clk),
        .we   (lb_we),
        .waddr(col[CW-1:1]),
        .wdata(top_max),
        .raddr(col[CW-1:1]),
        .rdata(lb_rdata)
    );

    // NOTE: non-blocking assignments for all registered state so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // NOTE: state_next defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (wr_en && final_write) state_next = ST_DONE;
            ST_DONE: if (start) state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col         <= '0;
            row         <= '0;
            plane       <= '0;
            pair        <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            plane_done  <= 1'b0;
            final_write <= 1'b0;
        end else begin
            wr_en       <= 1'b0;
            plane_done  <= 1'b0;
            final_write <= 1'b0;
            if (entering) begin
                col   <= '0;
                row   <= '0;
                plane <= '0;
                pair  <= '0;
            end else if (accept) begin
                if (last_col) begin
                    col <= '0;
                    if (last_row) begin
                        row   <= '0;
                        plane <= last_plane ? '0 : plane + 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    pair <= in_data;
                end else if (row[0]) begin
                    // Odd/odd pixel closes a window: pair, current pixel and buffered top-row max.
                    wr_en       <= 1'b1;
                    wr_data     <= win_max;
                    wr_addr     <= addr_full[AW-1:0];
                    plane_done  <= last_row && last_col;
                    final_write <= last_row && last_col && last_plane;
                end
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_writer.sv
// Scoreboard bench for pool2x2_writer: directed planes with hand-derived window maxima.
module tb_pool2x2_writer;

    localparam int COLS = 28;
    localparam int ROWS = 28;
    localparam int HC   = 14;
    localparam int PSZ  = 196;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_valid;
    logic signed [15:0] in_data;
    logic               wr_en;
    logic [15:0]        wr_addr;
    logic signed [15:0] wr_data;
    logic               plane_done;
    logic               busy;
    logic               done;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        pd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pool2x2_writer #(
        .COLS(28), .ROWS(28), .PLANES(6), .DW(16), .AW(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .plane_done(plane_done),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Mode 0: ramp row*28+col. 1: signed window 0, rest -32768. 2: all -32768. 3: operand-position windows.
    function automatic logic signed [15:0] pix(input int mode, input int r, input int c);
        int w[4][4];
        w = '{'{9, 1, 1, 1}, '{1, 1, 1, 9}, '{1, 9, 1, 1}, '{4, 4, 4, 4}};
        case (mode)
            0: return 16'(r * COLS + c);
            1: begin
                if (r == 0 && c == 0) return -16'sd5;
                if (r == 0 && c == 1) return -16'sd3;
                if (r == 1 && c == 0) return -16'sd7;
                if (r == 1 && c == 1) return -16'sd2;
                return -16'sd32768;
            end
            2: return -16'sd32768;
            default: begin
                if (r < 2 && c < 8) return 16'(w[c / 2][(r % 2) * 2 + (c % 2)]);
                return 16'sd0;
            end
        endcase
    endfunction

    function automatic int exp_val(input int mode, input int k);
        case (mode)
            0: return (2 * (k / HC) + 1) * COLS + 2 * (k % HC) + 1;
            1: return (k == 0) ? -2 : -32768;
            2: return -32768;
            default: return (k < 3) ? 9 : ((k == 3) ? 4 : 0);
        endcase
    endfunction

    // Entered and left #1 after a rising edge with in_valid low.
    task automatic drive_plane(input int mode, input int p, input int npix,
                               input bit gaps, input int start_at);
        for (int i = 0; i < npix; i++) begin
            int r, c, k;
            r = i / COLS;
            c = i % COLS;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = pix(mode, r, c);
            start    = (i == start_at);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                k = (r / 2) * HC + c / 2;
                sb.push_back('{addr: 16'(p * PSZ + k), data: 16'(exp_val(mode, k)), pd: (k == PSZ - 1)});
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            start    = 1'b0;
        end
    endtask

    task automatic drive_ignored(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i + 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && wr_en) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, $signed(e.data));
                check("plane_done", plane_done, e.pd);
                check("busy_done_excl", busy && done, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_plane_done", plane_done, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pixels in IDLE must be ignored, then a full 6-plane ramp run.
        drive_ignored(60);
        check("idle_busy", busy, 0);
        pulse_start();
        check("run_busy", busy, 1);
        drive_plane(0, 0, ROWS * COLS, 1'b0, -1);
        for (int p = 1; p < 6; p++) drive_plane(0, p, ROWS * COLS, 1'b1, (p == 1) ? 100 : -1);
        check("last_write_en", wr_en, 1);
        check("last_write_addr", wr_addr, 1175);
        check("done_during_last_write", done, 0);
        @(posedge clk);
        #1;
        check("done_after_last", done, 1);
        check("busy_after_last", busy, 0);
        check("sb_empty_run1", sb.size(), 0);

        // Pixels in DONE are ignored; done holds until start.
        drive_ignored(60);
        check("done_hold", done, 1);
        pulse_start();
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);
        drive_plane(1, 0, ROWS * COLS, 1'b0, 400);
        drive_plane(2, 1, ROWS * COLS, 1'b1, -1);
        drive_plane(3, 2, 300, 1'b0, -1);
        @(posedge clk);
        #1;
        check("sb_empty_before_rst", sb.size(), 0);

        // Abandon mid-plane.
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_wr_en", wr_en, 0);
        drive_ignored(60);
        pulse_start();
        drive_plane(0, 0, ROWS * COLS, 1'b1, -1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty_final", sb.size(), 0);
        check("final_busy", busy, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
